// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, latency, opcodes and response entry type
package alu_pkg;
  localparam int OPR_W = 3;
  localparam int OP_W = 4;
  localparam int RES_W = 6;
  localparam int ALU_LAT = 1;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0011;
  localparam logic [OP_W-1:0] OP_CMP = 4'b1100;
  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [RES_W-1:0] result;
  } rsp_t;
endpackage

// File: rtl/alu_cmd_issuer_rsp_fifo.sv
// rsp_fifo: generic synchronous circular FIFO with first-word head output
module rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic pop_ok;
  // Pops are ignored when empty; power-of-two depth lets pointers wrap by overflow
  always_comb begin
    pop_ok = pop && (cnt_q != '0);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_data;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop_ok);
  end
  // Storage and pointer registers; contents clear so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign head_data = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: credit-limited command issue to the ALU with in-order response FIFO
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_opcode,
  input  logic [OPR_W-1:0] cmd_a,
  input  logic [OPR_W-1:0] cmd_b,
  output logic [OP_W-1:0]  alu_opcode,
  output logic [OPR_W-1:0] alu_a,
  output logic [OPR_W-1:0] alu_b,
  input  logic [RES_W-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_result,
  output logic [OP_W-1:0]  rsp_opcode,
  output logic             busy
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [OP_W-1:0] alu_opcode_q, alu_opcode_d;
  logic [OPR_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [ALU_LAT-1:0] tag_v_q, tag_v_d;
  logic [ALU_LAT-1:0][OP_W-1:0] tag_op_q, tag_op_d;
  logic [CW-1:0] inflight_q, inflight_d, fifo_count;
  logic hs, cap;
  rsp_t push_data, head;
  assign cmd_ready = !rst && (({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW+1)'(DEPTH));
  // Latch operands on handshake and shift the ownership tag toward the capture stage
  always_comb begin
    hs = cmd_valid && cmd_ready;
    cap = tag_v_q[ALU_LAT-1];
    alu_opcode_d = hs ? cmd_opcode : alu_opcode_q;
    alu_a_d = hs ? cmd_a : alu_a_q;
    alu_b_d = hs ? cmd_b : alu_b_q;
    tag_v_d = tag_v_q << 1;
    tag_v_d[0] = hs;
    tag_op_d = tag_op_q << OP_W;
    tag_op_d[0] = cmd_opcode;
    inflight_d = inflight_q + CW'(hs) - CW'(cap);
    push_data = '{opcode: tag_op_q[ALU_LAT-1], result: alu_result};
  end
  // Operand, tag and in-flight registers; reset drops every pending tag
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      tag_v_q <= '0;
      tag_op_q <= '0;
      inflight_q <= '0;
    end else begin
      alu_opcode_q <= alu_opcode_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      tag_v_q <= tag_v_d;
      tag_op_q <= tag_op_d;
      inflight_q <= inflight_d;
    end
  end
  rsp_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(cap),
    .push_data(push_data),
    .pop(rsp_ready),
    .head_data(head),
    .count(fifo_count)
  );
  assign alu_opcode = alu_opcode_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign rsp_valid = fifo_count != '0;
  assign rsp_result = head.result;
  assign rsp_opcode = head.opcode;
  assign busy = (inflight_q != '0) || (fifo_count != '0);
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: scoreboard bench with directed and random traffic against an ALU stub
module tb_alu_cmd_issuer;
  import alu_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, cmd_valid = 0, rsp_ready = 0;
  logic cmd_ready, rsp_valid, busy;
  logic [OP_W-1:0] cmd_opcode = '0, alu_opcode, rsp_opcode;
  logic [OPR_W-1:0] cmd_a = '0, cmd_b = '0, alu_a, alu_b;
  logic [RES_W-1:0] alu_result, rsp_result;
  int errors = 0, checks = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_opcode(rsp_opcode),
    .busy(busy)
  );

  // ALU stub: result follows the registered alu_* operands within the same cycle
  assign alu_result = (alu_opcode == OP_ADD) ? RES_W'(alu_a) + RES_W'(alu_b) :
                      (alu_opcode == OP_MUL) ? RES_W'(alu_a) * RES_W'(alu_b) : '0;

  function automatic rsp_t model(logic [OP_W-1:0] op, logic [OPR_W-1:0] a, logic [OPR_W-1:0] b);
    int ia, ib, r;
    rsp_t e;
    ia = int'(a);
    ib = int'(b);
    r = (op == OP_MUL) ? ia * ib : ia + ib;
    e.opcode = op;
    e.result = RES_W'(r);
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [OP_W-1:0] op, logic [OPR_W-1:0] a, logic [OPR_W-1:0] b);
    cmd_valid = v;
    cmd_opcode = op;
    cmd_a = a;
    cmd_b = b;
  endtask

  task automatic drive_rand(logic v);
    drive(v, ($urandom_range(0, 1) != 0) ? OP_MUL : OP_ADD, OPR_W'($urandom), OPR_W'($urandom));
  endtask

  // Stimulus side of the scoreboard: every accepted command queues its expected response
  always @(negedge clk)
    if (!rst && cmd_valid && cmd_ready) exp_q.push_back(model(cmd_opcode, cmd_a, cmd_b));

  // Monitor: compare each consumed response with the queue head; reset discards pending work
  always @(negedge clk) begin
    rsp_t e;
    if (rst) exp_q.delete();
    else begin
      if (dut.cap) begin
        checks++;
        if (dut.fifo_count == DEPTH && !(rsp_valid && rsp_ready)) begin
          errors++;
          $display("FAIL fifo_overflow: push at count %0d without pop at %0t", dut.fifo_count, $time);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_result", rsp_result, e.result);
          chk("rsp_opcode", rsp_opcode, e.opcode);
        end
      end
    end
  end

  initial begin
    int n;
    drive(1, OP_ADD, 3'd1, 3'd1);
    tick();
    tick();
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_busy", busy, 0);
    tick();
    rst = 0;
    drive(0, OP_ADD, 0, 0);
    tick();
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    // single op
    tick();
    drive(1, OP_ADD, 3'b101, 3'b110);
    @(negedge clk);
    chk("single_ready", cmd_ready, 1);
    tick();
    drive(0, OP_ADD, 0, 0);
    @(negedge clk);
    chk("single_alu_a", alu_a, 5);
    chk("single_alu_b", alu_b, 6);
    chk("single_early_valid", rsp_valid, 0);
    tick();
    rsp_ready = 1;
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_result", rsp_result, 11);
    chk("single_rsp_opcode", rsp_opcode, OP_ADD);
    tick();
    rsp_ready = 0;
    @(negedge clk);
    chk("single_busy_after_pop", busy, 0);
    // back-to-back
    rsp_ready = 1;
    tick();
    drive(1, OP_ADD, 3'd5, 3'd6);
    tick();
    drive(1, OP_MUL, 3'd5, 3'd6);
    tick();
    drive(1, OP_ADD, 3'd5, 3'd6);
    @(negedge clk);
    chk("b2b_v0", rsp_valid, 1);
    chk("b2b_r0", rsp_result, 11);
    tick();
    drive(0, OP_ADD, 0, 0);
    @(negedge clk);
    chk("b2b_v1", rsp_valid, 1);
    chk("b2b_r1", rsp_result, 30);
    tick();
    @(negedge clk);
    chk("b2b_v2", rsp_valid, 1);
    chk("b2b_r2", rsp_result, 11);
    tick();
    @(negedge clk);
    chk("b2b_drained", rsp_valid, 0);
    // backpressure to full
    rsp_ready = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      drive_rand(1);
      @(negedge clk);
      if (cmd_ready) n++;
    end
    chk("full_handshakes", n, DEPTH);
    chk("full_cmd_ready", cmd_ready, 0);
    tick();
    rsp_ready = 1;
    @(negedge clk);
    chk("pop_same_cycle_ready", cmd_ready, 0);
    tick();
    rsp_ready = 0;
    @(negedge clk);
    chk("pop_credit_return", cmd_ready, 1);
    tick();
    @(negedge clk);
    chk("refull_cmd_ready", cmd_ready, 0);
    // sustained push/pop from full, pointers wrap
    rsp_ready = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      drive_rand(1);
      @(negedge clk);
      chk("stream_rsp_valid", rsp_valid, 1);
    end
    tick();
    drive(0, OP_ADD, 0, 0);
    repeat (4) tick();
    @(negedge clk);
    chk("stream_drained", busy, 0);
    // reset mid-flight
    rsp_ready = 0;
    tick();
    drive(1, OP_MUL, 3'd7, 3'd7);
    tick();
    drive(1, OP_ADD, 3'd7, 3'd7);
    tick();
    drive(0, OP_ADD, 0, 0);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    rsp_ready = 1;
    drive(1, OP_ADD, 3'd3, 3'd4);
    tick();
    drive(0, OP_ADD, 0, 0);
    @(negedge clk);
    chk("midrst_no_stale", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("midrst_next_valid", rsp_valid, 1);
    chk("midrst_next_result", rsp_result, 7);
    tick();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive_rand($urandom_range(0, 9) < 7);
      rsp_ready = $urandom_range(0, 9) < 6;
      tick();
    end
    drive(0, OP_ADD, 0, 0);
    rsp_ready = 1;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    @(negedge clk);
    chk("final_busy", busy, 0);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
